// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: a prescaler divides clk down to the oversample rate,
// and an oversample counter marks bit centres and bit boundaries.
module baud_tick_gen #(
    parameter int DIV_W   = 16,
    parameter int OS_RATE = 16,
    parameter int DEF_DIV = 325
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_ld,
    input  logic             restart,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic [DIV_W-1:0] div_cur
);

    localparam int OS_W = $clog2(OS_RATE);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS_RATE - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OS_RATE / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pre_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic             pre_wrap;

    assign pre_wrap = (pre_cnt == div_q - DIV_W'(1));
    assign div_cur  = div_q;

    always_ff @(posedge clk) begin
        // Ticks are single-cycle pulses: cleared every cycle unless a wrap sets them.
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
        if (rst) begin
            div_q   <= DIV_RST;
            pre_cnt <= '0;
            os_cnt  <= '0;
        end else if (div_ld) begin
            div_q   <= (div_in == '0) ? DIV_W'(1) : div_in;
            pre_cnt <= '0;
            os_cnt  <= '0;
        end else if (restart) begin
            pre_cnt <= '0;
            os_cnt  <= '0;
        end else if (en) begin
            if (pre_wrap) begin
                pre_cnt  <= '0;
                os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                os_tick  <= 1'b1;
                mid_tick <= (os_cnt == OS_MID);
                bit_tick <= (os_cnt == OS_LAST);
            end else begin
                pre_cnt <= pre_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: vector table, directed corner sequences and a random
// run checked against a count-based reference model.
module tb_baud_tick_gen;

    localparam int DIV_W   = 16;
    localparam int OS_RATE = 4;
    localparam int DEF_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0, en = 1'b0, div_ld = 1'b0, restart = 1'b0;
    logic [DIV_W-1:0] div_in = '0;
    logic             os_tick, mid_tick, bit_tick;
    logic [DIV_W-1:0] div_cur;

    baud_tick_gen #(.DIV_W(DIV_W), .OS_RATE(OS_RATE), .DEF_DIV(DEF_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_ld(div_ld),
        .restart(restart), .os_tick(os_tick), .mid_tick(mid_tick),
        .bit_tick(bit_tick), .div_cur(div_cur)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: count enabled counting cycles since the last clear; ticks fall
    // out of plain division on that count.
    int     m_div = DEF_DIV;
    longint m_cnt = 0;
    logic   m_os = 1'b0, m_mid = 1'b0, m_bit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        longint idx;
        m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
        if (rst) begin
            m_div = DEF_DIV; m_cnt = 0;
        end else if (div_ld) begin
            m_div = (div_in == 0) ? 1 : int'(div_in); m_cnt = 0;
        end else if (restart) begin
            m_cnt = 0;
        end else if (en) begin
            m_cnt++;
            if (m_cnt % m_div == 0) begin
                idx   = m_cnt / m_div;
                m_os  = 1'b1;
                m_mid = (idx % OS_RATE == OS_RATE / 2);
                m_bit = (idx % OS_RATE == 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("os_tick", {31'b0, os_tick}, {31'b0, m_os});
        chk("mid_tick", {31'b0, mid_tick}, {31'b0, m_mid});
        chk("bit_tick", {31'b0, bit_tick}, {31'b0, m_bit});
        chk("div_cur", {16'b0, div_cur}, m_div);
    endtask

    // sel: 0 os_tick, 1 mid_tick, 2 bit_tick. Returns cycles elapsed.
    task automatic wait_for(input int sel, input int budget, input string name, output int n);
        logic hit;
        n = 0; hit = 1'b0;
        while (!hit && n < budget) begin
            step();
            n++;
            hit = (sel == 0) ? os_tick : (sel == 1) ? mid_tick : bit_tick;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL %s: no tick within %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic             rst, en, ld;
        logic [DIV_W-1:0] din;
        logic             rs, os, mid, bt;
        int               div;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, logic l, logic [DIV_W-1:0] d, logic s,
                                logic o, logic m, logic b, int dv);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.din = d; v.rs = s;
        v.os = o; v.mid = m; v.bt = b; v.div = dv;
        return v;
    endfunction

    initial begin
        vec_t tbl[19];
        int   n, n2, tot;

        // Reset, then 16 enabled cycles at DEF_DIV=4: os every 4, mid at 8, bit at 16.
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 4);
        for (int k = 1; k <= 16; k++)
            tbl[k] = mk(0, 1, 0, 0, 0, (k % 4 == 0), (k == 8), (k == 16), 4);
        // rst wins over a simultaneous div_ld.
        tbl[17] = mk(1, 1, 1, 9, 0, 0, 0, 0, 4);
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 4);

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; div_ld = tbl[i].ld;
            div_in = tbl[i].din; restart = tbl[i].rs;
            step();
            chk($sformatf("vec%0d.os", i), {31'b0, os_tick}, {31'b0, tbl[i].os});
            chk($sformatf("vec%0d.mid", i), {31'b0, mid_tick}, {31'b0, tbl[i].mid});
            chk($sformatf("vec%0d.bit", i), {31'b0, bit_tick}, {31'b0, tbl[i].bt});
            chk($sformatf("vec%0d.div", i), {16'b0, div_cur}, tbl[i].div);
        end
        rst = 0; div_ld = 0; restart = 0; en = 1;

        // Divisor load mid-period.
        repeat (5) step();
        div_ld = 1; div_in = 10; step(); div_ld = 0;
        chk("ld10.div_cur", {16'b0, div_cur}, 10);
        chk("ld10.no_tick", {29'b0, os_tick, mid_tick, bit_tick}, 0);
        wait_for(0, 100, "ld10.os", n);
        chk("ld10.first_os", n, 10);
        wait_for(2, 100, "ld10.bit1", n2);
        chk("ld10.first_bit", n + n2, 40);
        wait_for(2, 100, "ld10.bit2", n);
        chk("ld10.bit_spacing", n, 40);

        // Zero divisor is treated as 1: os_tick every cycle.
        div_ld = 1; div_in = 0; step(); div_ld = 0;
        chk("ld0.div_cur", {16'b0, div_cur}, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ld0.os_cont", {31'b0, os_tick}, 1);
        end

        // Restart on the cycle a tick is due, at os_cnt=2.
        div_ld = 1; div_in = 5; step(); div_ld = 0;
        wait_for(0, 20, "rs.os1", n);
        wait_for(0, 20, "rs.os2", n);
        repeat (4) step();
        restart = 1; step(); restart = 0;
        chk("rs.suppressed", {29'b0, os_tick, mid_tick, bit_tick}, 0);
        chk("rs.div_kept", {16'b0, div_cur}, 5);
        wait_for(0, 50, "rs.os", n);
        chk("rs.first_os", n, 5);
        wait_for(1, 50, "rs.mid", n2);
        chk("rs.first_mid", n + n2, 10);
        wait_for(2, 50, "rs.bit", n);
        chk("rs.first_bit", n + n2 + 5, 20);

        // en low for 7 cycles mid-period delays the next os_tick by 7.
        restart = 1; step(); restart = 0;
        repeat (2) step();
        en = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("en_lo.ticks", {29'b0, os_tick, mid_tick, bit_tick}, 0);
        end
        en = 1;
        wait_for(0, 50, "en_lo.os", n);
        tot = 2 + 7 + n;
        chk("en_lo.delay", tot, 5 + 7);

        // div_ld with restart behaves as div_ld alone.
        repeat (2) step();
        div_ld = 1; restart = 1; div_in = 6; step(); div_ld = 0; restart = 0;
        chk("ldrs.div_cur", {16'b0, div_cur}, 6);
        wait_for(0, 50, "ldrs.os", n);
        chk("ldrs.first_os", n, 6);

        // Reset mid-period abandons the partial period.
        repeat (3) step();
        rst = 1; step(); rst = 0;
        chk("rst_mid.div", {16'b0, div_cur}, DEF_DIV);
        chk("rst_mid.ticks", {29'b0, os_tick, mid_tick, bit_tick}, 0);
        wait_for(0, 50, "rst_mid.os", n);
        chk("rst_mid.first_os", n, DEF_DIV);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            div_ld  = ($urandom_range(0, 59) == 0);
            div_in  = DIV_W'($urandom_range(0, 12));
            restart = ($urandom_range(0, 49) == 0);
            en      = ($urandom_range(0, 99) < 85);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
